// File: rtl/fp_add_scheduler.sv
// Round-robin scheduler sharing one combinational FP add/sub datapath among
// NUM_REQ requesters, with a multicycle hold before result capture.
module fp_add_scheduler #(
    parameter int NUM_REQ     = 4,
    parameter int ID_W        = 2,
    parameter int ADD_LATENCY = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [NUM_REQ*32-1:0]  req_a,
    input  logic [NUM_REQ*32-1:0]  req_b,
    input  logic [NUM_REQ-1:0]     req_op,
    output logic [31:0]            add_addent,
    output logic [31:0]            add_augend,
    input  logic [31:0]            add_result,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [ID_W-1:0]        rsp_id,
    output logic [31:0]            rsp_data,
    output logic [1:0]             rsp_flags,
    output logic                   busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t              state_r;
    state_t              state_nxt_s;
    logic [ID_W-1:0]     rr_ptr_r;
    logic [ID_W-1:0]     id_r;
    logic [31:0]         opa_r;
    logic [31:0]         opb_r;
    logic [3:0]          cnt_r;
    logic                rsp_valid_r;
    logic [ID_W-1:0]     rsp_id_r;
    logic [31:0]         rsp_data_r;
    logic [1:0]          rsp_flags_r;

    logic                grant_found_s;
    logic [ID_W-1:0]     grant_idx_s;
    logic [NUM_REQ-1:0]  grant_onehot_s;
    logic                accept_s;
    logic [31:0]         sel_a_s;
    logic [31:0]         sel_b_s;
    logic                sel_op_s;

    // {NaN, Inf} classification of an IEEE-754 single-precision value
    function automatic logic [1:0] classify(input logic [31:0] v);
        logic exp_ones;
        logic frac_nz;
        exp_ones = (v[30:23] == 8'hFF);
        frac_nz  = (v[22:0] != 23'd0);
        return {exp_ones & frac_nz, exp_ones & ~frac_nz};
    endfunction

    // Round-robin search from rr_ptr; descending scan so the nearest hit wins
    always_comb begin : arb
        int              idx_v;
        logic [ID_W-1:0] idx_w;
        idx_v         = 0;
        idx_w         = '0;
        grant_found_s = 1'b0;
        grant_idx_s   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx_v         = (int'(rr_ptr_r) + k) % NUM_REQ;
            idx_w         = ID_W'(idx_v);
            grant_found_s = grant_found_s | req_valid[idx_w];
            grant_idx_s   = req_valid[idx_w] ? idx_w : grant_idx_s;
        end
    end

    // Operand mux for the granted requester
    always_comb begin
        sel_a_s  = 32'd0;
        sel_b_s  = 32'd0;
        sel_op_s = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sel_a_s  = (grant_idx_s == ID_W'(i)) ? req_a[32*i +: 32] : sel_a_s;
            sel_b_s  = (grant_idx_s == ID_W'(i)) ? req_b[32*i +: 32] : sel_b_s;
            sel_op_s = (grant_idx_s == ID_W'(i)) ? req_op[i]         : sel_op_s;
        end
    end

    // No grant may leave the block while reset is asserted
    assign accept_s       = (state_r == IDLE) && grant_found_s && !rst;
    assign grant_onehot_s = NUM_REQ'(1) << grant_idx_s;
    assign req_ready      = accept_s ? grant_onehot_s : '0;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_nxt_s = WAIT;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            WAIT: begin
                if (cnt_r == 4'd1) begin
                    state_nxt_s = RESP;
                end else begin
                    state_nxt_s = WAIT;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = RESP;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Operand capture, latency counter and response registers
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_r    <= '0;
            id_r        <= '0;
            opa_r       <= 32'd0;
            opb_r       <= 32'd0;
            cnt_r       <= 4'd0;
            rsp_valid_r <= 1'b0;
            rsp_id_r    <= '0;
            rsp_data_r  <= 32'd0;
            rsp_flags_r <= 2'b00;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        opa_r    <= sel_a_s;
                        opb_r    <= {sel_b_s[31] ^ sel_op_s, sel_b_s[30:0]};
                        id_r     <= grant_idx_s;
                        rr_ptr_r <= ID_W'((int'(grant_idx_s) + 1) % NUM_REQ);
                        cnt_r    <= 4'(ADD_LATENCY);
                    end else begin
                        cnt_r    <= cnt_r;
                    end
                end
                WAIT: begin
                    cnt_r <= cnt_r - 4'd1;
                    if (cnt_r == 4'd1) begin
                        rsp_data_r  <= add_result;
                        rsp_flags_r <= classify(add_result);
                        rsp_id_r    <= id_r;
                        rsp_valid_r <= 1'b1;
                    end else begin
                        rsp_valid_r <= 1'b0;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_r <= 1'b0;
                    end else begin
                        rsp_valid_r <= 1'b1;
                    end
                end
                default: rsp_valid_r <= 1'b0;
            endcase
        end
    end

    assign add_addent = opa_r;
    assign add_augend = opb_r;
    assign rsp_valid  = rsp_valid_r;
    assign rsp_id     = rsp_id_r;
    assign rsp_data   = rsp_data_r;
    assign rsp_flags  = rsp_flags_r;
    assign busy       = (state_r == WAIT) || (state_r == RESP);

endmodule

// File: tb/tb_fp_add_scheduler.sv
// Directed bench for fp_add_scheduler: one instance with ADD_LATENCY=1 and one
// with ADD_LATENCY=3 for the reset-during-WAIT scenario.
module tb_fp_add_scheduler;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         rst3 = 1'b1;
    logic [3:0]   req_valid = 4'h0;
    logic [127:0] req_a = 128'd0;
    logic [127:0] req_b = 128'd0;
    logic [3:0]   req_op = 4'h0;
    logic         rsp_ready = 1'b1;

    logic [3:0]   req_ready, req_ready3;
    logic [31:0]  add_addent, add_augend, add_result;
    logic [31:0]  add_addent3, add_augend3, add_result3;
    logic         rsp_valid, rsp_valid3;
    logic [1:0]   rsp_id, rsp_id3;
    logic [31:0]  rsp_data, rsp_data3;
    logic [1:0]   rsp_flags, rsp_flags3;
    logic         busy, busy3;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    // Stand-in for the shared adder: exact sums for the directed vectors
    function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
        if (a == 32'h3F800000 && b == 32'h3F800000) return 32'h40000000;
        else if (a == 32'h40000000 && b == 32'hBF800000) return 32'h3F800000;
        else if (a == 32'h7FC00000) return 32'h7FC00000;
        else if (a == 32'h7F800000) return 32'h7F800000;
        else return a ^ b;
    endfunction

    assign add_result  = fadd(add_addent, add_augend);
    assign add_result3 = fadd(add_addent3, add_augend3);

    fp_add_scheduler #(.NUM_REQ(4), .ID_W(2), .ADD_LATENCY(1)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .add_addent(add_addent), .add_augend(add_augend), .add_result(add_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_flags(rsp_flags), .busy(busy)
    );

    fp_add_scheduler #(.NUM_REQ(4), .ID_W(2), .ADD_LATENCY(3)) dut3 (
        .clk(clk), .rst(rst3), .req_valid(req_valid), .req_ready(req_ready3),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .add_addent(add_addent3), .add_augend(add_augend3), .add_result(add_result3),
        .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready), .rsp_id(rsp_id3),
        .rsp_data(rsp_data3), .rsp_flags(rsp_flags3), .busy(busy3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [31:0] a_v;
        logic [31:0] b_v;

        // 1. reset with every requester valid
        req_valid = 4'hF;
        for (int i = 0; i < 4; i++) begin
            req_a[32*i +: 32] = 32'h11000000 + 32'(i);
            req_b[32*i +: 32] = 32'h00220000 + 32'(i * 16);
        end
        for (int c = 0; c < 2; c++) begin
            tick();
            chk("rst_req_ready", {28'd0, req_ready}, 32'd0);
            chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
            chk("rst_addent", add_addent, 32'd0);
            chk("rst_augend", add_augend, 32'd0);
            chk("rst_rsp_data", rsp_data, 32'd0);
            chk("rst_rsp_id_flags", {28'd0, rsp_id, rsp_flags}, 32'd0);
            chk("rst_busy", {31'd0, busy}, 32'd0);
        end
        rst = 1'b0;
        #1;
        chk("first_grant", {28'd0, req_ready}, 32'h1);
        tick();
        req_valid = 4'h0;
        #1;
        chk("wait_busy", {31'd0, busy}, 32'd1);
        chk("wait_req_ready", {28'd0, req_ready}, 32'd0);
        tick();
        chk("first_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("first_rsp_id", {30'd0, rsp_id}, 32'd0);
        tick();

        // 2. single add 1.0 + 1.0 from requester 2
        req_valid = 4'b0100;
        req_a[64 +: 32] = 32'h3F800000;
        req_b[64 +: 32] = 32'h3F800000;
        req_op = 4'b0000;
        #1;
        chk("single_req_ready", {28'd0, req_ready}, 32'h4);
        tick();
        chk("single_ready_drop", {28'd0, req_ready}, 32'd0);
        chk("single_rsp_early", {31'd0, rsp_valid}, 32'd0);
        tick();
        chk("single_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("single_rsp_data", rsp_data, 32'h40000000);
        chk("single_rsp_id", {30'd0, rsp_id}, 32'd2);
        chk("single_rsp_flags", {30'd0, rsp_flags}, 32'd0);
        chk("single_resp_no_grant", {28'd0, req_ready}, 32'd0);
        tick();
        chk("single_rsp_clear", {31'd0, rsp_valid}, 32'd0);
        chk("single_regrant", {28'd0, req_ready}, 32'h4);
        req_valid = 4'h0;

        // 3. round-robin from a fresh pointer
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req_op = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            req_a[32*i +: 32] = 32'h10000000 * 32'(i + 1) + 32'h00000100;
            req_b[32*i +: 32] = 32'h00030000 + 32'(i);
        end
        req_valid = 4'hF;
        for (int g = 0; g < 6; g++) begin
            #1;
            chk("rr_grant", {28'd0, req_ready}, 32'(1 << (g % 4)));
            tick();
            tick();
            a_v = 32'h10000000 * 32'((g % 4) + 1) + 32'h00000100;
            b_v = 32'h00030000 + 32'(g % 4);
            chk("rr_rsp_id", {30'd0, rsp_id}, 32'(g % 4));
            chk("rr_rsp_data", rsp_data, a_v ^ b_v);
            tick();
        end
        req_valid = 4'h0;

        // 4. subtract 2.0 - 1.0 from requester 1 under backpressure
        req_a[32 +: 32] = 32'h40000000;
        req_b[32 +: 32] = 32'h3F800000;
        req_op = 4'b0010;
        rsp_ready = 1'b0;
        req_valid = 4'b0010;
        #1;
        chk("sub_req_ready", {28'd0, req_ready}, 32'h2);
        tick();
        req_valid = 4'hF;
        chk("sub_addent", add_addent, 32'h40000000);
        chk("sub_augend", add_augend, 32'hBF800000);
        tick();
        for (int c = 0; c < 5; c++) begin
            chk("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            chk("bp_rsp_id", {30'd0, rsp_id}, 32'd1);
            chk("bp_rsp_data", rsp_data, 32'h3F800000);
            chk("bp_req_ready", {28'd0, req_ready}, 32'd0);
            tick();
        end
        rsp_ready = 1'b1;
        req_valid = 4'h0;
        #1;
        chk("bp_still_valid", {31'd0, rsp_valid}, 32'd1);
        tick();
        chk("bp_rsp_clear", {31'd0, rsp_valid}, 32'd0);
        chk("idle_hold_augend", add_augend, 32'hBF800000);
        req_op = 4'b0000;

        // 5. result flags: NaN from requester 2, Inf from requester 3
        req_a[64 +: 32] = 32'h7FC00000;
        req_b[64 +: 32] = 32'h3F800000;
        req_a[96 +: 32] = 32'h7F800000;
        req_b[96 +: 32] = 32'h3F800000;
        req_valid = 4'b0100;
        tick();
        req_valid = 4'h0;
        tick();
        chk("nan_flags", {30'd0, rsp_flags}, 32'h2);
        chk("nan_data", rsp_data, 32'h7FC00000);
        tick();
        req_valid = 4'b1000;
        tick();
        req_valid = 4'h0;
        tick();
        chk("inf_flags", {30'd0, rsp_flags}, 32'h1);
        chk("inf_data", rsp_data, 32'h7F800000);
        tick();

        // 6. reset during WAIT with ADD_LATENCY=3
        req_valid = 4'b1000;
        rst3 = 1'b0;
        #1;
        chk("l3_grant3", {28'd0, req_ready3}, 32'h8);
        tick();
        req_valid = 4'h0;
        tick();
        rst3 = 1'b1;
        req_valid = 4'b1010;
        tick();
        chk("l3_no_grant_in_rst", {28'd0, req_ready3}, 32'd0);
        chk("l3_no_rsp_in_rst", {31'd0, rsp_valid3}, 32'd0);
        rst3 = 1'b0;
        #1;
        chk("l3_grant1_first", {28'd0, req_ready3}, 32'h2);
        tick();
        req_valid = 4'b1000;
        for (int c = 0; c < 2; c++) begin
            chk("l3_no_rsp", {31'd0, rsp_valid3}, 32'd0);
            tick();
        end
        chk("l3_no_rsp_last", {31'd0, rsp_valid3}, 32'd0);
        tick();
        chk("l3_rsp1_valid", {31'd0, rsp_valid3}, 32'd1);
        chk("l3_rsp1_id", {30'd0, rsp_id3}, 32'd1);
        tick();
        chk("l3_grant3_next", {28'd0, req_ready3}, 32'h8);
        tick();
        req_valid = 4'h0;
        tick();
        tick();
        tick();
        chk("l3_rsp3_id", {30'd0, rsp_id3}, 32'd3);
        chk("l3_rsp3_valid", {31'd0, rsp_valid3}, 32'd1);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
